dco_sweep_ctrl: RTL

Frequency-sweep sequencer for the `sin_cos_dco` oscillator. On a start command it steps the DCO phase increment through a programmed list of points: start value, signed step, point count. For each point it:
- writes the increment to the DCO,
- waits out the DCO pipeline latency,
- opens a measurement window of programmed length,
- waits for the downstream measurement block to acknowledge before moving on.

It sits between the sensor control registers and the DCO `PHASE_INCREMENT_IN`/`PHASE_INCREMENT_IN_WE` inputs.

---
 rtl/dco_sweep_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/dco_sweep_ctrl.sv
// Frequency-sweep sequencer for sin_cos_dco: steps the phase increment through a
// programmed list of points, each followed by a settle gap, measurement window and ack handshake.
module dco_sweep_ctrl #(
  parameter int PHASE_INCREMENT_BITS = 28,
  parameter int POINT_BITS           = 10,
  parameter int DWELL_BITS           = 16,
  parameter int SETTLE_CYCLES        = 4
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            START,
  input  logic                            ABORT,
  input  logic [PHASE_INCREMENT_BITS-1:0] START_INC,
  input  logic [PHASE_INCREMENT_BITS-1:0] STEP_INC,
  input  logic [POINT_BITS-1:0]           STEP_COUNT,
  input  logic [DWELL_BITS-1:0]           DWELL,
  input  logic                            MEAS_ACK,
  output logic [PHASE_INCREMENT_BITS-1:0] PHASE_INCREMENT_OUT,
  output logic                            PHASE_INCREMENT_WE,
  output logic                            WINDOW,
  output logic [POINT_BITS-1:0]           POINT_INDEX,
  output logic                            POINT_DONE,
  output logic                            BUSY,
  output logic                            DONE
);

  // One counter serves both the settle gap (up to 255) and the dwell window.
  localparam int CNT_BITS = (DWELL_BITS > 8) ? DWELL_BITS : 8;
  localparam logic [CNT_BITS-1:0] SETTLE_LAST =
    CNT_BITS'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
  localparam logic [CNT_BITS-1:0]   CNT_ONE   = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [POINT_BITS-1:0] IDX_ONE   = {{(POINT_BITS-1){1'b0}}, 1'b1};
  localparam logic [DWELL_BITS-1:0] DWELL_ONE = {{(DWELL_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_SETTLE   = 3'd2,
    S_DWELL    = 3'd3,
    S_WAIT_ACK = 3'd4
  } state_t;

  state_t                          state_q, state_d;
  logic [CNT_BITS-1:0]             cnt_q, cnt_d;
  logic [PHASE_INCREMENT_BITS-1:0] step_q, step_d;
  logic [PHASE_INCREMENT_BITS-1:0] inc_q, inc_d;
  logic [POINT_BITS-1:0]           last_idx_q, last_idx_d;
  logic [POINT_BITS-1:0]           idx_q, idx_d;
  logic [DWELL_BITS-1:0]           dwell_last_q, dwell_last_d;
  logic                            we_q, we_d;
  logic                            window_q, window_d;
  logic                            pd_q, pd_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;

  logic abort_s;
  logic accept_s;
  logic settle_end_s;
  logic dwell_end_s;
  logic last_point_s;

  assign abort_s      = ABORT && (state_q != S_IDLE);
  assign accept_s     = START && !ABORT;
  assign settle_end_s = (cnt_q == SETTLE_LAST);
  assign dwell_end_s  = (cnt_q[DWELL_BITS-1:0] == dwell_last_q);
  assign last_point_s = (idx_q == last_idx_q);

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort returns to IDLE from any active state.
  always_comb begin
    state_d = state_q;
    if (abort_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) state_d = S_LOAD;
          else          state_d = S_IDLE;
        end
        S_LOAD: begin
          if (SETTLE_CYCLES == 0) state_d = S_DWELL;
          else                    state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_end_s) state_d = S_DWELL;
          else              state_d = S_SETTLE;
        end
        S_DWELL: begin
          if (dwell_end_s) state_d = S_WAIT_ACK;
          else             state_d = S_DWELL;
        end
        S_WAIT_ACK: begin
          if (!MEAS_ACK)         state_d = S_WAIT_ACK;
          else if (last_point_s) state_d = S_IDLE;
          else                   state_d = S_LOAD;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values; pulses default low, everything else holds.
  always_comb begin
    cnt_d        = cnt_q;
    step_d       = step_q;
    inc_d        = inc_q;
    last_idx_d   = last_idx_q;
    idx_d        = idx_q;
    dwell_last_d = dwell_last_q;
    we_d         = 1'b0;
    window_d     = window_q;
    pd_d         = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    if (abort_s) begin
      window_d = 1'b0;
      busy_d   = 1'b0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            // Zero count/dwell are treated as one; store last index / last dwell cycle.
            step_d       = STEP_INC;
            last_idx_d   = (STEP_COUNT == '0) ? '0 : (STEP_COUNT - IDX_ONE);
            dwell_last_d = (DWELL == '0) ? '0 : (DWELL - DWELL_ONE);
            inc_d        = START_INC;
            idx_d        = '0;
            we_d         = 1'b1;
            busy_d       = 1'b1;
            window_d     = 1'b0;
            cnt_d        = '0;
          end else begin
            cnt_d = '0;
          end
        end
        S_LOAD: begin
          cnt_d = '0;
          if (SETTLE_CYCLES == 0) window_d = 1'b1;
          else                    window_d = 1'b0;
        end
        S_SETTLE: begin
          if (settle_end_s) begin
            window_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_DWELL: begin
          if (dwell_end_s) begin
            window_d = 1'b0;
            pd_d     = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_WAIT_ACK: begin
          if (!MEAS_ACK) begin
            cnt_d = '0;
          end else if (last_point_s) begin
            // Increment and index hold so the DCO stays on the final point.
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            idx_d = idx_q + IDX_ONE;
            inc_d = inc_q + step_q;
            we_d  = 1'b1;
          end
        end
        default: begin
          window_d = 1'b0;
          busy_d   = 1'b0;
          cnt_d    = '0;
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q        <= '0;
      step_q       <= '0;
      inc_q        <= '0;
      last_idx_q   <= '0;
      idx_q        <= '0;
      dwell_last_q <= '0;
      we_q         <= 1'b0;
      window_q     <= 1'b0;
      pd_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      inc_q        <= inc_d;
      last_idx_q   <= last_idx_d;
      idx_q        <= idx_d;
      dwell_last_q <= dwell_last_d;
      we_q         <= we_d;
      window_q     <= window_d;
      pd_q         <= pd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign PHASE_INCREMENT_OUT = inc_q;
  assign PHASE_INCREMENT_WE  = we_q;
  assign WINDOW              = window_q;
  assign POINT_INDEX         = idx_q;
  assign POINT_DONE          = pd_q;
  assign BUSY                = busy_q;
  assign DONE                = done_q;

endmodule
